control_unit: RTL and testbench

- Multi-cycle fetch/decode/execute/writeback controller for the 16-bit datapath.
- Fetches instructions from instruction memory over a req/ack handshake and decodes them.
- Drives the register bank read/write addresses and its write enable, plus the ALU operation and immediate select.
- Updates the program counter, including conditional and unconditional branches.

---
 rtl/cu_pkg.sv | 52 +++++
 rtl/instr_decoder.sv | 53 +++++
 rtl/control_unit.sv | 142 ++++++++++++++
 tb/tb_control_unit.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Types shared by the control unit, its decoder and the ALU.
// Also holds the datapath sizes and the bit positions of the instruction fields.
package cu_pkg;

    localparam int SIZE_REG = 16;
    localparam int ADDR_REG = 2;
    localparam int PC_WIDTH = 8;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 10;
    localparam int RA_HI  = 9;
    localparam int RA_LO  = 8;
    localparam int RB_HI  = 7;
    localparam int RB_LO  = 6;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_MOV  = 4'h6,
        OP_LDI  = 4'h7,
        OP_BZ   = 4'h8,
        OP_JMP  = 4'h9,
        OP_HALT = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        ALU_PASS_A = 3'd0,
        ALU_ADD    = 3'd1,
        ALU_SUB    = 3'd2,
        ALU_AND    = 3'd3,
        ALU_OR     = 3'd4,
        ALU_XOR    = 3'd5,
        ALU_PASS_B = 3'd6
    } alu_op_t;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_WRITEBACK = 3'd3,
        ST_HALTED    = 3'd4
    } state_t;

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational instruction decoder.
// Splits an instruction word into register fields, ALU controls and control-flow flags.
module instr_decoder
    import cu_pkg::*;
(
    input  logic [SIZE_REG-1:0] i_ir,
    output logic [ADDR_REG-1:0] o_ra,
    output logic [ADDR_REG-1:0] o_rb,
    output logic [ADDR_REG-1:0] o_rd,
    output logic [2:0]          o_alu_op,
    output logic                o_imm_sel,
    output logic [SIZE_REG-1:0] o_imm_value,
    output logic                o_writes_rd,
    output logic                o_is_branch,
    output logic                o_is_jump,
    output logic                o_is_halt,
    output logic                o_illegal
);

    opcode_t w_opcode;

    assign w_opcode    = opcode_t'(i_ir[OPC_HI:OPC_LO]);
    assign o_rd        = i_ir[RD_HI:RD_LO];
    assign o_ra        = i_ir[RA_HI:RA_LO];
    assign o_rb        = i_ir[RB_HI:RB_LO];
    assign o_imm_value = {{(SIZE_REG - 8){1'b0}}, i_ir[IMM_HI:IMM_LO]};

    // Opcode to ALU operation and control-flow class
    always_comb begin
        o_alu_op    = ALU_PASS_A;
        o_imm_sel   = 1'b0;
        o_writes_rd = 1'b0;
        o_is_branch = 1'b0;
        o_is_jump   = 1'b0;
        o_is_halt   = 1'b0;
        o_illegal   = 1'b0;
        case (w_opcode)
            OP_NOP:  o_alu_op = ALU_PASS_A;
            OP_ADD:  begin o_alu_op = ALU_ADD;    o_writes_rd = 1'b1; end
            OP_SUB:  begin o_alu_op = ALU_SUB;    o_writes_rd = 1'b1; end
            OP_AND:  begin o_alu_op = ALU_AND;    o_writes_rd = 1'b1; end
            OP_OR:   begin o_alu_op = ALU_OR;     o_writes_rd = 1'b1; end
            OP_XOR:  begin o_alu_op = ALU_XOR;    o_writes_rd = 1'b1; end
            OP_MOV:  begin o_alu_op = ALU_PASS_A; o_writes_rd = 1'b1; end
            OP_LDI:  begin o_alu_op = ALU_PASS_B; o_writes_rd = 1'b1; o_imm_sel = 1'b1; end
            OP_BZ:   begin o_alu_op = ALU_PASS_A; o_is_branch = 1'b1; end
            OP_JMP:  o_is_jump = 1'b1;
            OP_HALT: o_is_halt = 1'b1;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute/writeback controller for the 16-bit datapath.
// Owns the FSM, the program counter and the instruction register.
module control_unit
    import cu_pkg::*;
#(
    parameter int size_reg = SIZE_REG,
    parameter int addr_reg = ADDR_REG,
    parameter int pc_width = PC_WIDTH
) (
    input  logic                clock,
    input  logic                reset,
    output logic [pc_width-1:0] imem_addr,
    output logic                imem_req,
    input  logic                imem_ack,
    input  logic [size_reg-1:0] imem_data,
    input  logic                zero_flag,
    output logic [addr_reg-1:0] addr_A,
    output logic [addr_reg-1:0] addr_B,
    output logic [addr_reg-1:0] addr_R,
    output logic                write_reg,
    output logic [2:0]          alu_op,
    output logic                imm_sel,
    output logic [size_reg-1:0] imm_value,
    output logic                halted,
    output logic                illegal_op
);

    state_t              r_state;
    logic [pc_width-1:0] r_pc;
    logic [size_reg-1:0] r_ir;
    logic [addr_reg-1:0] r_addr_a, r_addr_b, r_addr_r;
    logic [2:0]          r_alu_op;
    logic                r_imm_sel, r_write_reg, r_halted, r_illegal_op;
    logic [size_reg-1:0] r_imm_value;

    logic                w_fetch_ack;
    logic [size_reg-1:0] w_ir_next, w_imm_value;
    logic [addr_reg-1:0] w_ra, w_rb, w_rd;
    logic [2:0]          w_alu_op;
    logic                w_imm_sel, w_writes_rd, w_is_branch, w_is_jump, w_is_halt, w_illegal;
    logic [pc_width-1:0] w_pc_inc, w_pc_exec;

    // Decode the word being latched on the ack cycle so its fields register alongside ir
    assign w_fetch_ack = (r_state == ST_FETCH) && imem_ack;
    assign w_ir_next   = w_fetch_ack ? imem_data : r_ir;

    instr_decoder u_decoder (
        .i_ir        (w_ir_next),
        .o_ra        (w_ra),
        .o_rb        (w_rb),
        .o_rd        (w_rd),
        .o_alu_op    (w_alu_op),
        .o_imm_sel   (w_imm_sel),
        .o_imm_value (w_imm_value),
        .o_writes_rd (w_writes_rd),
        .o_is_branch (w_is_branch),
        .o_is_jump   (w_is_jump),
        .o_is_halt   (w_is_halt),
        .o_illegal   (w_illegal)
    );

    // Next pc for instructions that leave EXECUTE straight back to FETCH
    always_comb begin
        w_pc_inc = r_pc + pc_width'(1'b1);
        if (w_is_jump) begin
            w_pc_exec = pc_width'(r_imm_value[7:0]);
        end else if (w_is_branch && zero_flag) begin
            w_pc_exec = w_pc_inc + pc_width'($signed(r_imm_value[7:0]));
        end else begin
            w_pc_exec = w_pc_inc;
        end
    end

    // FSM, pc, ir and every registered output
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_FETCH;
            r_pc         <= {pc_width{1'b0}};
            r_ir         <= {size_reg{1'b0}};
            r_addr_a     <= {addr_reg{1'b0}};
            r_addr_b     <= {addr_reg{1'b0}};
            r_addr_r     <= {addr_reg{1'b0}};
            r_alu_op     <= 3'd0;
            r_imm_sel    <= 1'b0;
            r_imm_value  <= {size_reg{1'b0}};
            r_write_reg  <= 1'b0;
            r_halted     <= 1'b0;
            r_illegal_op <= 1'b0;
        end else begin
            r_write_reg  <= 1'b0;
            r_illegal_op <= 1'b0;
            case (r_state)
                ST_FETCH: begin
                    if (imem_ack) begin
                        r_ir         <= imem_data;
                        r_addr_a     <= w_ra;
                        r_addr_b     <= w_rb;
                        r_addr_r     <= w_rd;
                        r_alu_op     <= w_alu_op;
                        r_imm_sel    <= w_imm_sel;
                        r_imm_value  <= w_imm_value;
                        r_illegal_op <= w_illegal;
                        r_state      <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    r_halted <= w_is_halt;
                    r_state  <= w_is_halt ? ST_HALTED : ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    if (w_writes_rd) begin
                        r_write_reg <= 1'b1;
                        r_state     <= ST_WRITEBACK;
                    end else begin
                        r_pc    <= w_pc_exec;
                        r_state <= ST_FETCH;
                    end
                end
                ST_WRITEBACK: begin
                    r_pc    <= w_pc_inc;
                    r_state <= ST_FETCH;
                end
                ST_HALTED: r_state <= ST_HALTED;
                default:   r_state <= ST_FETCH;
            endcase
        end
    end

    // Request gated by reset so it is low while reset is held and high on the first cycle after
    assign imem_req   = (r_state == ST_FETCH) && !reset;
    assign imem_addr  = r_pc;
    assign addr_A     = r_addr_a;
    assign addr_B     = r_addr_b;
    assign addr_R     = r_addr_r;
    assign write_reg  = r_write_reg;
    assign alu_op     = r_alu_op;
    assign imm_sel    = r_imm_sel;
    assign imm_value  = r_imm_value;
    assign halted     = r_halted;
    assign illegal_op = r_illegal_op;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: an instruction-memory responder feeds a reference model
// that queues expected fetches, writes and illegal pulses; a monitor checks them as they appear.
module tb_control_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  imem_addr;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_data = 16'h0000;
    logic        zero_flag = 1'b0;
    logic [1:0]  addr_A, addr_B, addr_R;
    logic        write_reg;
    logic [2:0]  alu_op;
    logic        imm_sel;
    logic [15:0] imm_value;
    logic        halted;
    logic        illegal_op;

    control_unit dut (
        .clock      (clock),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .zero_flag  (zero_flag),
        .addr_A     (addr_A),
        .addr_B     (addr_B),
        .addr_R     (addr_R),
        .write_reg  (write_reg),
        .alu_op     (alu_op),
        .imm_sel    (imm_sel),
        .imm_value  (imm_value),
        .halted     (halted),
        .illegal_op (illegal_op)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct { int addr; int cyc; } fetch_t;
    typedef struct { int rd; int ra; int rb; int alu; int isel; int imm; int cyc; } wr_t;

    fetch_t q_fetch[$];
    wr_t    q_wr[$];
    int     q_ill[$];
    bit     zq[$];

    logic [15:0] mem [0:255];
    int checks = 0;
    int errors = 0;
    int m_pc = 0;
    int fixed_delay = 0;
    int max_delay = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic int pick_delay();
        if (fixed_delay >= 0) return fixed_delay;
        return int'($urandom_range(0, max_delay));
    endfunction

    // Reference model: architectural effect of one instruction acked at cycle c
    task automatic model_step(input logic [15:0] ins, input bit z, input int c);
        int op, nxt, lat, off;
        bit more;
        wr_t w;
        fetch_t f;
        op   = int'(ins[15:12]);
        nxt  = (m_pc + 1) % 256;
        lat  = 3;
        more = 1'b1;
        w.rd = int'(ins[11:10]); w.ra = int'(ins[9:8]); w.rb = int'(ins[7:6]);
        w.imm = int'(ins[7:0]); w.cyc = c + 3; w.isel = 0; w.alu = 0;
        if (op >= 1 && op <= 7) begin
            lat   = 4;
            w.alu = (op == 7) ? 6 : ((op == 6) ? 0 : op);
            w.isel = (op == 7) ? 1 : 0;
            q_wr.push_back(w);
        end else if (op == 8) begin
            off = ins[7] ? int'(ins[7:0]) - 256 : int'(ins[7:0]);
            if (z) nxt = (m_pc + 1 + off + 256) % 256;
        end else if (op == 9) begin
            nxt = int'(ins[7:0]);
        end else if (op == 15) begin
            more = 1'b0;
        end else if (op != 0) begin
            q_ill.push_back(c + 1);
        end
        if (more) begin
            f.addr = nxt;
            f.cyc  = c + lat;
            q_fetch.push_back(f);
        end
        m_pc = nxt;
    endtask

    // Instruction memory responder: acks n requests after a chosen delay
    task automatic run(input int n);
        int done, d, guard;
        logic [15:0] ins;
        bit z;
        done = 0;
        guard = 0;
        d = pick_delay();
        while (done < n && guard < 20 * n + 50) begin
            @(negedge clock);
            guard++;
            imem_ack = 1'b0;
            if (imem_req === 1'b1) begin
                if (d == 0) begin
                    ins = mem[imem_addr];
                    if (ins[15:12] == 4'h8 && zq.size() > 0) z = zq.pop_front();
                    else z = bit'($urandom_range(0, 1));
                    imem_data = ins;
                    zero_flag = z;
                    imem_ack  = 1'b1;
                    model_step(ins, z, cyc);
                    done++;
                    d = pick_delay();
                end else begin
                    d--;
                end
            end
        end
        if (done < n) fail_now("responder_timeout");
        @(negedge clock);
        imem_ack = 1'b0;
    endtask

    task automatic apply_reset(input int n);
        fetch_t f;
        @(negedge clock);
        reset = 1'b1;
        imem_ack = 1'b0;
        q_fetch.delete();
        q_wr.delete();
        q_ill.delete();
        repeat (n) @(negedge clock);
        reset = 1'b0;
        m_pc = 0;
        f.addr = 0;
        f.cyc  = cyc;
        q_fetch.push_back(f);
    endtask

    task automatic quiesce();
        repeat (8) @(negedge clock);
        chk("fetch_queue_drained", q_fetch.size(), 0);
        chk("write_queue_drained", q_wr.size(), 0);
        chk("illegal_queue_drained", q_ill.size(), 0);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    // Monitor: compares DUT events against the scoreboard queues
    initial begin
        logic prev_req;
        logic [7:0] prev_addr;
        fetch_t f;
        wr_t w;
        int ic;
        prev_req = 1'b0;
        prev_addr = 8'h00;
        forever begin
            @(negedge clock);
            #1;
            if (imem_req === 1'b1) begin
                if (prev_req) begin
                    chk("fetch_addr_stable", imem_addr, prev_addr);
                end else if (q_fetch.size() == 0) begin
                    fail_now("unexpected_fetch");
                end else begin
                    f = q_fetch.pop_front();
                    chk("fetch_addr", imem_addr, f.addr);
                    chk("fetch_cycle", cyc, f.cyc);
                end
            end
            if (write_reg !== 1'b0) begin
                if (q_wr.size() == 0) begin
                    fail_now("unexpected_write_reg");
                end else begin
                    w = q_wr.pop_front();
                    chk("write_cycle", cyc, w.cyc);
                    chk("addr_R", addr_R, w.rd);
                    chk("addr_A", addr_A, w.ra);
                    chk("addr_B", addr_B, w.rb);
                    chk("alu_op", alu_op, w.alu);
                    chk("imm_sel", imm_sel, w.isel);
                    chk("imm_value", imm_value, w.imm);
                end
            end
            if (illegal_op !== 1'b0) begin
                if (q_ill.size() == 0) begin
                    fail_now("unexpected_illegal_op");
                end else begin
                    ic = q_ill.pop_front();
                    chk("illegal_cycle", cyc, ic);
                end
            end
            prev_req  = (imem_req === 1'b1);
            prev_addr = imem_addr;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        clear_mem();
        repeat (3) @(negedge clock);
        #1;
        chk("rst_imem_req", imem_req, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_write_reg", write_reg, 0);
        chk("rst_halted", halted, 0);
        chk("rst_illegal_op", illegal_op, 0);
        chk("rst_addr_A", addr_A, 0);
        chk("rst_addr_B", addr_B, 0);
        chk("rst_addr_R", addr_R, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_imm_sel", imm_sel, 0);

        // LDI r0,0x2A everywhere
        for (int i = 0; i < 256; i++) mem[i] = 16'h702A;
        fixed_delay = 0;
        apply_reset(2);
        run(3);
        quiesce();

        // ADD r3,r1,r2 behind a slow memory
        clear_mem();
        mem[0] = 16'h1D80;
        fixed_delay = 5;
        apply_reset(2);
        run(1);
        quiesce();

        // BZ r1,-3 at pc 5, taken then not taken
        clear_mem();
        mem[0] = 16'h9005;
        mem[5] = 16'h81FD;
        mem[3] = 16'h9005;
        fixed_delay = 0;
        zq.push_back(1'b1);
        zq.push_back(1'b0);
        apply_reset(2);
        run(4);
        quiesce();

        // JMP 0xFF then NOP wraps to 0; illegal opcode at 0x42
        clear_mem();
        mem[0]   = 16'h90FF;
        mem[255] = 16'h0000;
        apply_reset(2);
        run(2);
        quiesce();
        clear_mem();
        mem[0]    = 16'h9042;
        mem[8'h42] = 16'hC5A5;
        apply_reset(2);
        run(2);
        quiesce();

        // HALT is sticky until reset
        clear_mem();
        mem[0] = 16'hF000;
        apply_reset(2);
        run(1);
        repeat (2) @(negedge clock);
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            #1;
            chk("halted_held", halted, 1);
            chk("halted_no_req", imem_req, 0);
        end
        apply_reset(1);
        #1;
        chk("halted_cleared", halted, 0);
        quiesce();

        // Reset lands on the edge that would enter WRITEBACK of an ADD
        clear_mem();
        mem[0] = 16'h1D80;
        apply_reset(2);
        run(1);
        apply_reset(1);
        #1;
        chk("reset_drops_write", write_reg, 0);
        chk("reset_pc_zero", imem_addr, 0);
        quiesce();

        // Random program, random memory latency and zero_flag
        for (int i = 0; i < 256; i++) begin
            mem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
        end
        fixed_delay = -1;
        max_delay = 3;
        apply_reset(2);
        run(150);
        quiesce();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
